trng_sample_ctrl: RTL

Sequencing controller for the TRNG entropy path. Powers up the ring oscillators, waits out a warm-up interval, then strobes raw oscillator samples into the Von Neumann corrector at a fixed rate. It packs the corrector's debiased bits into words and hands each word to the consumer over a valid/ready handshake. It sits between the oscillator/synchronizer front end, the corrector, and the AXI-side word FIFO.

---
 rtl/trng_pkg.sv | 20 ++
 rtl/trng_rct.sv | 58 +++++
 rtl/trng_sample_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG sampling controller.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FAIL   = 3'd4
    } trng_state_e;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_RCT_LIMIT = 32;

    // Oscillators run (and the block reports busy) in every working state.
    function automatic logic state_active(input trng_state_e s);
        return (s == ST_WARMUP) || (s == ST_SAMPLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: flags RCT_LIMIT consecutive identical samples.
// fail is combinational so the controller can react on the same edge the
// offending sample is taken.
module trng_rct
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT = DEF_RCT_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic fail
);

    localparam int RUN_W = $clog2(RCT_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_LIMIT);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(RCT_LIMIT - 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    logic             repeat_bit;

    assign repeat_bit = (run_q != '0) && (bit_in == last_q);

    // Track the current run length of identical samples.
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (clear) begin
            run_d  = '0;
            last_d = 1'b0;
        end else if (bit_valid) begin
            last_d = bit_in;
            if (repeat_bit) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
            end else begin
                run_d = RUN_W'(1);
            end
        end
    end

    // The sample that would extend the run to RCT_LIMIT trips the test.
    assign fail = bit_valid && !clear && repeat_bit && (run_q >= RUN_TRIP);

    // Run-length state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/trng_sample_ctrl.sv
// TRNG entropy-path sequencer: oscillator warm-up, divided sample strobes into
// the Von Neumann corrector, word packing and valid/ready word hand-off.
// Build option: define TRNG_HEALTH_EN to add the repetition-count health test
// (trng_rct) and the FAIL state; otherwise health_fail is tied low.
//
// Handshake: word_data is offered while word_valid is high and stays stable;
// a word transfers on any clock edge where word_valid && word_ready, and
// word_valid does not depend combinationally on word_ready.
module trng_sample_ctrl
    import trng_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1024,
    parameter int SAMPLE_DIV    = 16,
    parameter int WORD_W        = DEF_WORD_W,
    parameter int RCT_LIMIT     = DEF_RCT_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic              osc_en,
    input  logic              raw_bit,
    output logic              vn_rst,
    output logic              sample_bit,
    output logic              sample_valid,
    input  logic              corr_bit,
    input  logic              corr_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              health_fail
);

    if (WARMUP_CYCLES < 1 || SAMPLE_DIV < 2 || WORD_W < 2 || RCT_LIMIT < 2) begin : g_param_check
        $error("trng_sample_ctrl: illegal parameter value");
    end

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int BIT_W  = $clog2(WORD_W + 1);

    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(WORD_W);

    trng_state_e        state_q, state_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               stop_pend_q, stop_pend_d;
    logic               osc_en_q, osc_en_d;
    logic               vn_rst_q, vn_rst_d;
    logic               sample_bit_q, sample_bit_d;
    logic               sample_valid_q, sample_valid_d;
    logic               word_valid_q, word_valid_d;
    logic               busy_q, busy_d;
    logic               health_fail_q, health_fail_d;
    logic               div_last;
    logic               rct_fail;

    assign div_last = (div_q == DIV_LAST);

`ifdef TRNG_HEALTH_EN
    // Health test sees each raw sample as it is strobed; cleared on WARMUP entry.
    trng_rct #(
        .RCT_LIMIT (RCT_LIMIT)
    ) u_rct (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (vn_rst_d),
        .bit_in    (raw_bit),
        .bit_valid ((state_q == ST_SAMPLE) && div_last),
        .fail      (rct_fail)
    );
`else
    assign rct_fail = 1'b0;
`endif

    // Next-state, counter and packing logic.
    always_comb begin
        state_d       = state_q;
        warm_cnt_d    = warm_cnt_q;
        div_d         = div_q;
        bit_cnt_d     = bit_cnt_q;
        word_d        = word_q;
        stop_pend_d   = stop_pend_q;
        health_fail_d = health_fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = '0;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (warm_cnt_q == WARM_LAST) begin
                    state_d   = ST_SAMPLE;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    word_d    = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (corr_valid) begin
                    word_d    = {word_q[WORD_W-2:0], corr_bit};
                    bit_cnt_d = (bit_cnt_q == BIT_FULL) ? bit_cnt_q : bit_cnt_q + 1'b1;
                end
                if (stop) begin
                    state_d   = ST_IDLE;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    word_d    = '0;
                end else if (rct_fail) begin
                    state_d       = ST_FAIL;
                    health_fail_d = 1'b1;
                    div_d         = '0;
                    bit_cnt_d     = '0;
                    word_d        = '0;
                end else if (corr_valid && (bit_cnt_q == BIT_LAST)) begin
                    state_d     = ST_HOLD;
                    stop_pend_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (word_valid_q && word_ready) begin
                    state_d     = (stop || stop_pend_q) ? ST_IDLE : ST_SAMPLE;
                    div_d       = '0;
                    bit_cnt_d   = '0;
                    word_d      = '0;
                    stop_pend_d = 1'b0;
                end
            end
            ST_FAIL: begin
                if (start && !stop) begin
                    state_d       = ST_WARMUP;
                    warm_cnt_d    = '0;
                    health_fail_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        osc_en_d       = state_active(state_d);
        busy_d         = state_active(state_d);
        vn_rst_d       = (state_d == ST_WARMUP) && (state_q != ST_WARMUP);
        sample_valid_d = (state_q == ST_SAMPLE) && div_last &&
                         ((state_d == ST_SAMPLE) || (state_d == ST_FAIL));
        sample_bit_d   = sample_valid_d ? raw_bit : sample_bit_q;
        word_valid_d   = (state_d == ST_HOLD);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            warm_cnt_q     <= '0;
            div_q          <= '0;
            bit_cnt_q      <= '0;
            word_q         <= '0;
            stop_pend_q    <= 1'b0;
            osc_en_q       <= 1'b0;
            vn_rst_q       <= 1'b0;
            sample_bit_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            word_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            health_fail_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            warm_cnt_q     <= warm_cnt_d;
            div_q          <= div_d;
            bit_cnt_q      <= bit_cnt_d;
            word_q         <= word_d;
            stop_pend_q    <= stop_pend_d;
            osc_en_q       <= osc_en_d;
            vn_rst_q       <= vn_rst_d;
            sample_bit_q   <= sample_bit_d;
            sample_valid_q <= sample_valid_d;
            word_valid_q   <= word_valid_d;
            busy_q         <= busy_d;
            health_fail_q  <= health_fail_d;
        end
    end

    assign osc_en       = osc_en_q;
    assign vn_rst       = vn_rst_q;
    assign sample_bit   = sample_bit_q;
    assign sample_valid = sample_valid_q;
    assign word_data    = word_q;
    assign word_valid   = word_valid_q;
    assign busy         = busy_q;
    assign health_fail  = health_fail_q;

endmodule
